// File: rtl/water_supply_pkg.sv
// Shared types, level codes and sensor-pattern constants for the tank level reader.
// Patterns are ordered {high, mid, low}; 1 means the probe is submerged.
package water_supply_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_EMPTY = 3'd1,
        ST_LOW   = 3'd2,
        ST_MID   = 3'd3,
        ST_FULL  = 3'd4,
        ST_FAULT = 3'd5
    } level_state_t;

    localparam logic [1:0] LEVEL_EMPTY = 2'd0;
    localparam logic [1:0] LEVEL_LOW   = 2'd1;
    localparam logic [1:0] LEVEL_MID   = 2'd2;
    localparam logic [1:0] LEVEL_FULL  = 2'd3;

    localparam logic [2:0] PATTERN_EMPTY = 3'b000;
    localparam logic [2:0] PATTERN_LOW   = 3'b001;
    localparam logic [2:0] PATTERN_MID   = 3'b011;
    localparam logic [2:0] PATTERN_FULL  = 3'b111;

    // Water fills from the bottom, so a higher probe wet above a dry lower one is physically impossible.
    function automatic logic pattern_is_valid(input logic [2:0] pattern);
        return (pattern == PATTERN_EMPTY) || (pattern == PATTERN_LOW) ||
               (pattern == PATTERN_MID)   || (pattern == PATTERN_FULL);
    endfunction

    function automatic level_state_t pattern_to_state(input logic [2:0] pattern);
        level_state_t st;
        case (pattern)
            PATTERN_EMPTY: st = ST_EMPTY;
            PATTERN_LOW:   st = ST_LOW;
            PATTERN_MID:   st = ST_MID;
            PATTERN_FULL:  st = ST_FULL;
            default:       st = ST_FAULT;
        endcase
        return st;
    endfunction

    function automatic logic [1:0] state_to_code(input level_state_t st);
        logic [1:0] code;
        case (st)
            ST_LOW:  code = LEVEL_LOW;
            ST_MID:  code = LEVEL_MID;
            ST_FULL: code = LEVEL_FULL;
            default: code = LEVEL_EMPTY;
        endcase
        return code;
    endfunction

    function automatic logic is_level_state(input level_state_t st);
        return (st == ST_EMPTY) || (st == ST_LOW) || (st == ST_MID) || (st == ST_FULL);
    endfunction

endpackage

// File: rtl/water_level_sensor_reader_if.sv
// Probe inputs and level/status outputs of the water level reader, bundled as one port.
// The master side drives the probes; the slave side is the reader itself.
interface water_level_sensor_reader_if;

    logic       raw_low_sensor;
    logic       raw_mid_sensor;
    logic       raw_high_sensor;
    logic       water_sensors_conflicting;
    logic       high_water_level;
    logic       low_water_level;
    logic [1:0] level_code;
    logic       level_valid;
    logic       fault_latched;

    modport master (
        output raw_low_sensor,
        output raw_mid_sensor,
        output raw_high_sensor,
        input  water_sensors_conflicting,
        input  high_water_level,
        input  low_water_level,
        input  level_code,
        input  level_valid,
        input  fault_latched
    );

    modport slave (
        input  raw_low_sensor,
        input  raw_mid_sensor,
        input  raw_high_sensor,
        output water_sensors_conflicting,
        output high_water_level,
        output low_water_level,
        output level_code,
        output level_valid,
        output fault_latched
    );

endinterface

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a persistence debouncer for one tank probe.
// The stable value only follows the synchronized probe after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module sensor_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [7:0] COUNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       stable_q;
    logic       stable_d;
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle agreeing with the stable value restarts the persistence count.
    always_comb begin
        stable_d = stable_q;
        count_d  = '0;
        if (sync2_q != stable_q) begin
            if (count_q == COUNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/water_level_sensor_reader.sv
// Tank level reader: debounces three probes, tracks the level in an FSM and flags implausible readings.
// All outputs are registered from the next state so nothing combinational reaches them from the probes.
module water_level_sensor_reader
    import water_supply_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int FAULT_HOLD_CYCLES = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    water_level_sensor_reader_if.slave   bus
);

    localparam logic [8:0] INIT_LAST = 9'(DEBOUNCE_CYCLES + 1);
    localparam logic [8:0] HOLD_LAST = 9'(FAULT_HOLD_CYCLES - 1);

    logic         stable_low;
    logic         stable_mid;
    logic         stable_high;
    logic [2:0]   pattern;
    logic         pattern_ok;

    level_state_t state_q;
    level_state_t state_d;
    logic [8:0]   cnt_q;
    logic [8:0]   cnt_d;

    logic         conflicting_q;
    logic         conflicting_d;
    logic         high_q;
    logic         high_d;
    logic         low_q;
    logic         low_d;
    logic [1:0]   code_q;
    logic [1:0]   code_d;
    logic         valid_q;
    logic         valid_d;
    logic         latched_q;
    logic         latched_d;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_low_debouncer (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (bus.raw_low_sensor),
        .stable_o (stable_low)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mid_debouncer (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (bus.raw_mid_sensor),
        .stable_o (stable_mid)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_high_debouncer (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (bus.raw_high_sensor),
        .stable_o (stable_high)
    );

    assign pattern    = {stable_high, stable_mid, stable_low};
    assign pattern_ok = pattern_is_valid(pattern);

    // One counter serves INIT settling time and the fault entry/exit persistence, since they never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    cnt_d   = '0;
                    state_d = pattern_ok ? pattern_to_state(pattern) : ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_FAULT: begin
                if (!pattern_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = pattern_to_state(pattern);
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                if (pattern_ok) begin
                    cnt_d   = '0;
                    state_d = pattern_to_state(pattern);
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
        endcase
    end

    always_comb begin
        conflicting_d = (state_d == ST_INIT) || (state_d == ST_FAULT) || !pattern_ok;
        high_d        = (state_d == ST_FULL);
        low_d         = (state_d == ST_EMPTY);
        valid_d       = is_level_state(state_d) && pattern_ok;
        code_d        = valid_d ? state_to_code(state_d) : LEVEL_EMPTY;
        latched_d     = latched_q || (state_d == ST_FAULT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            conflicting_q <= 1'b1;
            high_q        <= 1'b0;
            low_q         <= 1'b0;
            code_q        <= LEVEL_EMPTY;
            valid_q       <= 1'b0;
            latched_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            conflicting_q <= conflicting_d;
            high_q        <= high_d;
            low_q         <= low_d;
            code_q        <= code_d;
            valid_q       <= valid_d;
            latched_q     <= latched_d;
        end
    end

    assign bus.water_sensors_conflicting = conflicting_q;
    assign bus.high_water_level          = high_q;
    assign bus.low_water_level           = low_q;
    assign bus.level_code                = code_q;
    assign bus.level_valid               = valid_q;
    assign bus.fault_latched             = latched_q;

endmodule

// File: tb/tb_water_level_sensor_reader.sv
// Directed and randomized bench for the water level reader, checked against a cycle-level reference model.
module tb_water_level_sensor_reader;

    localparam int DEB = 4;
    localparam int FH  = 3;

    localparam int M_INIT  = 0;
    localparam int M_EMPTY = 1;
    localparam int M_FULL  = 4;
    localparam int M_FAULT = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    water_level_sensor_reader_if bus();

    water_level_sensor_reader #(
        .DEBOUNCE_CYCLES   (DEB),
        .FAULT_HOLD_CYCLES (FH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model state: probe samples delayed through the synchronizer, recent samples, accepted pattern.
    bit [2:0] delayQ[$];
    bit [2:0] seenQ[$];
    bit [2:0] stableM;
    int       mState;
    int       initEdges;
    int       invRun;
    int       valRun;
    bit       latchM;

    bit       expConf;
    bit       expHigh;
    bit       expLow;
    bit       expValid;
    bit       expLatch;
    bit [1:0] expCode;

    bit [2:0] climbPat[3];
    bit [2:0] validPats[4];

    // Level 0..3 for the four physically possible patterns, -1 for any other.
    function automatic int levelOf(input bit [2:0] pat);
        int lvl;
        case (pat)
            3'b000:  lvl = 0;
            3'b001:  lvl = 1;
            3'b011:  lvl = 2;
            3'b111:  lvl = 3;
            default: lvl = -1;
        endcase
        return lvl;
    endfunction

    task automatic modelEdge(input bit rst, input bit [2:0] rawPat);
        int       lvl;
        bit [2:0] seen;
        bit       allDiffer;
        bit       isLevel;
        if (rst) begin
            delayQ    = '{3'b000, 3'b000};
            seenQ.delete();
            stableM   = 3'b000;
            mState    = M_INIT;
            initEdges = 0;
            invRun    = 0;
            valRun    = 0;
            latchM    = 1'b0;
            expConf   = 1'b1;
            expHigh   = 1'b0;
            expLow    = 1'b0;
            expValid  = 1'b0;
            expCode   = 2'd0;
            expLatch  = 1'b0;
        end else begin
            lvl = levelOf(stableM);
            if (lvl < 0) begin
                invRun++;
                valRun = 0;
            end else begin
                valRun++;
                invRun = 0;
            end
            if (mState == M_INIT) begin
                initEdges++;
                if (initEdges == DEB + 2) mState = (lvl < 0) ? M_FAULT : M_EMPTY + lvl;
            end else if (mState == M_FAULT) begin
                if (valRun >= FH) mState = M_EMPTY + lvl;
            end else begin
                if (lvl >= 0) mState = M_EMPTY + lvl;
                else if (invRun >= FH) mState = M_FAULT;
            end
            isLevel  = (mState != M_INIT) && (mState != M_FAULT);
            expConf  = !isLevel || (lvl < 0);
            expHigh  = (mState == M_FULL);
            expLow   = (mState == M_EMPTY);
            expValid = isLevel && (lvl >= 0);
            expCode  = expValid ? 2'(mState - M_EMPTY) : 2'd0;
            if (mState == M_FAULT) latchM = 1'b1;
            expLatch = latchM;

            seen = delayQ.pop_front();
            delayQ.push_back(rawPat);
            seenQ.push_back(seen);
            if (seenQ.size() > DEB) void'(seenQ.pop_front());
            for (int i = 0; i < 3; i++) begin
                if (seenQ.size() == DEB) begin
                    allDiffer = 1'b1;
                    for (int k = 0; k < DEB; k++) begin
                        if (seenQ[k][i] == stableM[i]) allDiffer = 1'b0;
                    end
                    if (allDiffer) stableM[i] = ~stableM[i];
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit [2:0] pat);
        reset               = rst;
        bus.raw_high_sensor = pat[2];
        bus.raw_mid_sensor  = pat[1];
        bus.raw_low_sensor  = pat[0];
        @(posedge clock);
        modelEdge(rst, pat);
        #1;
        checkOutput("model_conflicting", 4'(bus.water_sensors_conflicting), 4'(expConf));
        checkOutput("model_high",        4'(bus.high_water_level),          4'(expHigh));
        checkOutput("model_low",         4'(bus.low_water_level),           4'(expLow));
        checkOutput("model_valid",       4'(bus.level_valid),               4'(expValid));
        checkOutput("model_code",        4'(bus.level_code),                4'(expCode));
        checkOutput("model_latched",     4'(bus.fault_latched),             4'(expLatch));
    endtask

    initial begin
        bit [2:0] pat;
        int       len;

        climbPat  = '{3'b001, 3'b011, 3'b111};
        validPats = '{3'b000, 3'b001, 3'b011, 3'b111};
        $display("[TB] start DEB=%0d FH=%0d", DEB, FH);

        repeat (3) applyStimulus(1'b1, 3'b000);
        checkOutput("reset_conflicting", 4'(bus.water_sensors_conflicting), 4'd1);
        checkOutput("reset_low",         4'(bus.low_water_level),           4'd0);
        checkOutput("reset_valid",       4'(bus.level_valid),               4'd0);
        checkOutput("reset_code",        4'(bus.level_code),                4'd0);

        for (int i = 1; i <= DEB + 1; i++) begin
            applyStimulus(1'b0, 3'b000);
            checkOutput("init_conflicting", 4'(bus.water_sensors_conflicting), 4'd1);
            checkOutput("init_valid",       4'(bus.level_valid),               4'd0);
        end
        applyStimulus(1'b0, 3'b000);
        checkOutput("empty_low",         4'(bus.low_water_level),           4'd1);
        checkOutput("empty_code",        4'(bus.level_code),                4'd0);
        checkOutput("empty_valid",       4'(bus.level_valid),               4'd1);
        checkOutput("empty_conflicting", 4'(bus.water_sensors_conflicting), 4'd0);
        repeat (5) applyStimulus(1'b0, 3'b000);

        $display("[TB] short pulse on low probe");
        repeat (DEB - 1) applyStimulus(1'b0, 3'b001);
        repeat (12) applyStimulus(1'b0, 3'b000);
        checkOutput("glitch_code",  4'(bus.level_code),      4'd0);
        checkOutput("glitch_low",   4'(bus.low_water_level), 4'd1);
        checkOutput("glitch_valid", 4'(bus.level_valid),     4'd1);

        $display("[TB] filling low, mid, high");
        for (int s = 0; s < 3; s++) begin
            repeat (DEB + 2) applyStimulus(1'b0, climbPat[s]);
            checkOutput("climb_before", 4'(bus.level_code), 4'(s));
            applyStimulus(1'b0, climbPat[s]);
            checkOutput("climb_code", 4'(bus.level_code), 4'(s + 1));
            repeat (20 - (DEB + 3)) applyStimulus(1'b0, climbPat[s]);
        end
        checkOutput("full_high", 4'(bus.high_water_level), 4'd1);

        $display("[TB] mid probe drops out while full");
        repeat (DEB + 3) applyStimulus(1'b0, 3'b101);
        checkOutput("conflict_flag",    4'(bus.water_sensors_conflicting), 4'd1);
        checkOutput("conflict_valid",   4'(bus.level_valid),               4'd0);
        checkOutput("conflict_code",    4'(bus.level_code),                4'd0);
        checkOutput("conflict_high",    4'(bus.high_water_level),          4'd1);
        repeat (FH - 2) applyStimulus(1'b0, 3'b101);
        checkOutput("prefault_latched", 4'(bus.fault_latched),             4'd0);
        applyStimulus(1'b0, 3'b101);
        checkOutput("fault_latched",    4'(bus.fault_latched),             4'd1);
        checkOutput("fault_high",       4'(bus.high_water_level),          4'd0);
        repeat (DEB + 2 + FH - 1) applyStimulus(1'b0, 3'b111);
        checkOutput("recover_pending",  4'(bus.water_sensors_conflicting), 4'd1);
        applyStimulus(1'b0, 3'b111);
        checkOutput("recover_high",     4'(bus.high_water_level),          4'd1);
        checkOutput("recover_code",     4'(bus.level_code),                4'd3);
        checkOutput("recover_conflict", 4'(bus.water_sensors_conflicting), 4'd0);
        checkOutput("recover_latched",  4'(bus.fault_latched),             4'd1);

        $display("[TB] drain, then all probes rise together");
        repeat (20) applyStimulus(1'b0, 3'b000);
        checkOutput("drain_low", 4'(bus.low_water_level), 4'd1);
        repeat (DEB + 2) applyStimulus(1'b0, 3'b111);
        checkOutput("jump_before", 4'(bus.level_code), 4'd0);
        applyStimulus(1'b0, 3'b111);
        checkOutput("jump_code", 4'(bus.level_code),       4'd3);
        checkOutput("jump_high", 4'(bus.high_water_level), 4'd1);

        $display("[TB] reset while in fault");
        repeat (15) applyStimulus(1'b0, 3'b010);
        checkOutput("infault_latched", 4'(bus.fault_latched), 4'd1);
        applyStimulus(1'b1, 3'b010);
        checkOutput("rstfault_latched",     4'(bus.fault_latched),             4'd0);
        checkOutput("rstfault_conflicting", 4'(bus.water_sensors_conflicting), 4'd1);
        checkOutput("rstfault_high",        4'(bus.high_water_level),          4'd0);
        checkOutput("rstfault_valid",       4'(bus.level_valid),               4'd0);

        $display("[TB] randomized probe activity");
        for (int seg = 0; seg < 90; seg++) begin
            if ($urandom_range(0, 9) < 6) pat = validPats[$urandom_range(0, 3)];
            else pat = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 2)) applyStimulus(1'b1, pat);
            end else begin
                repeat (len) applyStimulus(1'b0, pat);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/water_level_sensor_reader.md
WATER_LEVEL_SENSOR_READER -- requirements
Module: water_level_sensor_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles a sensor change must persist before it is accepted (range 1..255).
REQ-002 SHALL have parameter FAULT_HOLD_CYCLES, default 3: consecutive cycles an invalid or valid pattern must persist before FAULT entry or exit (range 1..255).
REQ-003 SHALL have port clock, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports raw_low_sensor, raw_mid_sensor, raw_high_sensor, input, 1 each: asynchronous tank probes, 1 = submerged.
REQ-006 SHALL have port water_sensors_conflicting, output, 1: 1 = sensor readings untrusted, so the supply valve must close.
REQ-007 SHALL have port high_water_level, output, 1: tank full.
REQ-008 SHALL have port low_water_level, output, 1: tank empty.
REQ-009 SHALL have port level_code, output, 2: EMPTY=0, LOW=1, MID=2, FULL=3.
REQ-010 SHALL have port level_valid, output, 1: level_code is trustworthy.
REQ-011 SHALL have port fault_latched, output, 1: sticky indication that FAULT was entered; cleared only by reset.

Function
REQ-012 SHALL pass each raw sensor through a two-flop synchronizer.
REQ-013 SHALL debounce each synchronized sensor: per-sensor counter increments while synced value differs from stable value, clears when equal, and the stable value toggles and counter clears when count reaches DEBOUNCE_CYCLES.
REQ-014 SHALL produce a raw-edge-to-output latency of exactly DEBOUNCE_CYCLES+3 cycles (2 sync, DEBOUNCE_CYCLES debounce, 1 FSM register); pulses shorter than DEBOUNCE_CYCLES SHALL have no effect.
REQ-015 SHALL treat stable pattern {high,mid,low} as valid only for 000, 001, 011 and 111; all others are invalid.
REQ-016 SHALL implement FSM states INIT, EMPTY, LOW, MID, FULL and FAULT.
REQ-017 INIT SHALL last DEBOUNCE_CYCLES+2 cycles after reset release and then go to the state matching the stable pattern, or to FAULT if that pattern is invalid.
REQ-018 From EMPTY, LOW, MID or FULL, a valid pattern SHALL move the FSM directly to its matching state in one cycle, including non-adjacent jumps such as EMPTY to FULL.
REQ-019 From a level state, an invalid pattern SHALL hold the state and start a hold counter, and the FSM SHALL enter FAULT when the pattern has stayed invalid for FAULT_HOLD_CYCLES consecutive cycles; any valid cycle clears the counter.
REQ-020 FAULT SHALL exit to the matching level state only after FAULT_HOLD_CYCLES consecutive valid cycles, and the counter SHALL clear on any invalid cycle.
REQ-021 water_sensors_conflicting SHALL be 1 in INIT, in FAULT, and on any cycle whose stable pattern is invalid; otherwise it is 0.
REQ-022 high_water_level SHALL be 1 only in FULL, and low_water_level SHALL be 1 only in EMPTY.
REQ-023 level_valid SHALL be 1 only in a level state with a valid current pattern, and level_code SHALL be 0 whenever level_valid is 0.
REQ-024 fault_latched SHALL be set on FAULT entry and SHALL remain set until reset.
REQ-025 All outputs SHALL be registered with no combinational path from any raw input.

Reset
REQ-026 On reset, synchronizers, stable values and counters SHALL clear to 0, the FSM SHALL go to INIT, water_sensors_conflicting SHALL be 1, and all other outputs SHALL be 0.
REQ-027 Reset asserted in any state, including mid-debounce or FAULT, SHALL take effect on the next clock edge and abort all counts.

Structure
REQ-028 The shared package water_supply_pkg SHALL hold the level_state_t enum, the LEVEL_EMPTY/LOW/MID/FULL code constants and the valid-pattern constants.
REQ-029 Per-sensor synchronizer plus debouncer SHALL be sub-module sensor_debouncer (parameter DEBOUNCE_CYCLES), instantiated three times.

Verification (DEBOUNCE_CYCLES=4, FAULT_HOLD_CYCLES=3)
REQ-030 Reset with all sensors 0 SHALL keep conflicting=1 for 6 cycles, after which EMPTY is reached with low_water_level=1, level_code=0, level_valid=1 and conflicting=0.
REQ-031 Raising low, then mid, then high 20 cycles apart SHALL give level_code 1, 2, 3, each exactly 7 cycles after its edge, with high_water_level=1 at the last step.
REQ-032 A 3-cycle pulse on raw_low_sensor from EMPTY SHALL leave all outputs unchanged.
REQ-033 From FULL, dropping mid only (pattern 101) SHALL set conflicting=1 and level_valid=0 at once, enter FAULT with fault_latched=1 after 3 invalid cycles, and return to FULL 3 valid cycles after mid restores, with fault_latched still 1.
REQ-034 All three sensors rising in the same cycle from EMPTY SHALL move directly to FULL with no intermediate level_code.
REQ-035 Reset asserted while in FAULT SHALL return all outputs to reset values, including fault_latched=0 and conflicting=1.
